// File: rtl/prog_loader.sv
// Byte-stream program loader: length-prefixed image -> little-endian 32-bit
// instruction-memory writes, holding the core in reset until the image is in.
//
// state  | meaning
// HDR0   | waiting for N[7:0]
// HDR1   | waiting for N[15:8]; decides DONE / ERR / DATA
// DATA   | packing bytes into words, one write per 4 bytes
// DONE   | image loaded, core released, stream stalled
// ERR    | header rejected (N > DEPTH_WORDS), stream stalled
module prog_loader #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [7:0]    i_in_data,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic          i_reload,
  output logic          o_imem_we,
  output logic [AW-1:0] o_imem_addr,
  output logic [31:0]   o_imem_wdata,
  output logic          o_core_rst,
  output logic          o_done,
  output logic          o_err
);

  localparam logic [2:0] S_HDR0 = 3'd0;
  localparam logic [2:0] S_HDR1 = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

  logic [2:0]    r_state;
  logic [15:0]   r_n;
  logic [15:0]   r_k;
  logic [1:0]    r_b;
  logic [31:0]   r_asm;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;

  logic          w_xfer;
  logic [15:0]   w_n_full;
  logic          w_last_word;

  assign w_xfer      = i_in_valid & o_in_ready;
  assign w_n_full    = {i_in_data, r_n[7:0]};
  assign w_last_word = (r_k == (r_n - 16'd1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_HDR0;
      r_n     <= '0;
      r_k     <= '0;
      r_b     <= '0;
      r_asm   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      // A reload wins over any byte offered in the same cycle; a write already
      // registered last cycle has been presented and is unaffected.
      if (i_reload) begin
        r_state <= S_HDR0;
        r_n     <= '0;
        r_k     <= '0;
        r_b     <= '0;
        r_asm   <= '0;
      end else begin
        case (r_state)
          S_HDR0: begin
            if (w_xfer) begin
              r_n[7:0] <= i_in_data;
              r_state  <= S_HDR1;
            end
          end
          S_HDR1: begin
            if (w_xfer) begin
              r_n[15:8] <= i_in_data;
              if (w_n_full == 16'd0) begin
                r_state <= S_DONE;
              end else if ({1'b0, w_n_full} > DEPTH_L) begin
                r_state <= S_ERR;
              end else begin
                r_state <= S_DATA;
                r_k     <= '0;
                r_b     <= '0;
                r_asm   <= '0;
              end
            end
          end
          S_DATA: begin
            if (w_xfer) begin
              r_asm[{r_b, 3'b000} +: 8] <= i_in_data;
              r_b <= r_b + 2'd1;
              if (r_b == 2'd3) begin
                // The final write and the core release land on the same edge.
                r_we    <= 1'b1;
                r_addr  <= AW'({r_k, 2'b00});
                r_wdata <= {i_in_data, r_asm[23:0]};
                r_k     <= r_k + 16'd1;
                if (w_last_word) begin
                  r_state <= S_DONE;
                end
              end
            end
          end
          S_DONE, S_ERR: begin
            r_state <= r_state;
          end
          default: begin
            r_state <= S_HDR0;
          end
        endcase
      end
    end
  end

  assign o_in_ready   = (r_state == S_HDR0) | (r_state == S_HDR1) | (r_state == S_DATA);
  assign o_core_rst   = (r_state != S_DONE);
  assign o_done       = (r_state == S_DONE);
  assign o_err        = (r_state == S_ERR);
  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_addr;
  assign o_imem_wdata = r_wdata;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: images built from word lists, expected writes derived
// from the image contents and the byte-acceptance cycles seen by the driver.
module tb_prog_loader;
  localparam int DEPTH = 64;
  localparam int AW    = 8;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];
  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          crst;
    logic          dn;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          reload = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          done;
  logic          err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  wr_t obs[$];
  int  acc_cyc[$];

  prog_loader #(.DEPTH_WORDS(DEPTH), .AW(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_data(in_data), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .i_reload(reload), .o_imem_we(imem_we),
    .o_imem_addr(imem_addr), .o_imem_wdata(imem_wdata), .o_core_rst(core_rst),
    .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (imem_we === 1'b1) obs.push_back('{cyc, imem_addr, imem_wdata, core_rst, done});

  function automatic bq_t make_image(input int n, input wq_t words);
    bq_t q;
    q.push_back(8'(n));
    q.push_back(8'(n >> 8));
    foreach (words[i]) for (int j = 0; j < 4; j++) q.push_back(8'(words[i] >> (8 * j)));
    return q;
  endfunction

  task automatic pulse_reload();
    @(negedge clk); reload = 1'b1;
    @(negedge clk); reload = 1'b0;
  endtask

  task automatic start_test();
    pulse_reload();
    obs.delete();
    acc_cyc.delete();
  endtask

  // gap_mode: 0 = every cycle, 1 = alternate, 2 = random
  task automatic send(input bq_t bytes, input int gap_mode);
    int i = 0;
    int guard = 0;
    logic v, rdy;
    while (i < bytes.size() && guard < 4000) begin
      @(negedge clk);
      guard++;
      v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? 1'(guard % 2) : 1'($urandom_range(0, 1));
      in_valid = v;
      in_data  = bytes[i];
      rdy = in_ready;
      @(posedge clk); #1;
      if (v && rdy) begin
        if (i >= 2 && ((i - 2) % 4) == 3) acc_cyc.push_back(cyc);
        i++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (i != bytes.size()) begin
      bad++;
      $display("FAIL send_timeout: accepted %0d of %0d bytes", i, bytes.size());
    end
  endtask

  task automatic check_load(input string name, input wq_t words);
    int n;
    repeat (3) @(negedge clk);
    n = (obs.size() < words.size()) ? obs.size() : words.size();
    total++;
    if (obs.size() != words.size()) begin
      bad++;
      $display("FAIL %s write_count: got %0d want %0d", name, obs.size(), words.size());
    end
    for (int i = 0; i < n; i++) begin
      total++;
      if (obs[i].addr !== AW'(4 * i) || obs[i].data !== words[i]) begin
        bad++;
        $display("FAIL %s write%0d: got addr=%h data=%h want addr=%h data=%h",
                 name, i, obs[i].addr, obs[i].data, AW'(4 * i), words[i]);
      end
      total++;
      if (i < acc_cyc.size() && obs[i].cyc !== acc_cyc[i]) begin
        bad++;
        $display("FAIL %s latency%0d: we in cycle %0d want %0d", name, i, obs[i].cyc, acc_cyc[i]);
      end
      total++;
      if (obs[i].crst !== (i != words.size() - 1) || obs[i].dn !== (i == words.size() - 1)) begin
        bad++;
        $display("FAIL %s release%0d: core_rst=%b done=%b during write, last=%0d",
                 name, i, obs[i].crst, obs[i].dn, (i == words.size() - 1));
      end
    end
    total++;
    if (done !== 1'b1 || in_ready !== 1'b0 || core_rst !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL %s final: done=%b in_ready=%b core_rst=%b err=%b want 1 0 0 0",
               name, done, in_ready, core_rst, err);
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (in_ready !== 1'b1 || imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== 32'h0 ||
        core_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%b we=%b addr=%h wdata=%h crst=%b done=%b err=%b",
               in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, err);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || core_rst !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: rdy=%b crst=%b want 1 1", in_ready, core_rst);
    end
  endtask

  task automatic test_nominal(input int gap_mode, input string name);
    wq_t w = '{32'h00A00513, 32'h00100593};
    bq_t img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    start_test();
    send(img, gap_mode);
    check_load(name, w);
  endtask

  task automatic test_zero();
    start_test();
    send('{8'h00, 8'h00}, 0);
    repeat (3) @(negedge clk);
    total++;
    if (obs.size() != 0 || done !== 1'b1 || core_rst !== 1'b0 || in_ready !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL zero_hdr: writes=%0d done=%b crst=%b rdy=%b err=%b want 0 1 0 0 0",
               obs.size(), done, core_rst, in_ready, err);
    end
  endtask

  task automatic test_oversize();
    start_test();
    send('{8'h41, 8'h00}, 0);
    repeat (2) @(negedge clk);
    total++;
    if (err !== 1'b1 || core_rst !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0 || obs.size() != 0) begin
      bad++;
      $display("FAIL oversize: err=%b crst=%b rdy=%b done=%b writes=%0d want 1 1 0 0 0",
               err, core_rst, in_ready, done, obs.size());
    end
    pulse_reload();
    total++;
    if (err !== 1'b0 || in_ready !== 1'b1 || core_rst !== 1'b1) begin
      bad++;
      $display("FAIL oversize_reload: err=%b rdy=%b crst=%b want 0 1 1", err, in_ready, core_rst);
    end
  endtask

  task automatic test_abort();
    start_test();
    send('{8'h01, 8'h00, 8'h11, 8'h22}, 0);
    // reload with a byte offered in the same cycle: that byte must be dropped
    @(negedge clk); reload = 1'b1; in_valid = 1'b1; in_data = 8'h03;
    @(negedge clk); reload = 1'b0; in_valid = 1'b0;
    total++;
    if (obs.size() != 0 || in_ready !== 1'b1 || core_rst !== 1'b1) begin
      bad++;
      $display("FAIL abort_state: writes=%0d rdy=%b crst=%b want 0 1 1", obs.size(), in_ready, core_rst);
    end
    send('{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 0);
    check_load("abort", '{32'hDEADBEEF});
  endtask

  task automatic test_async_reset();
    wq_t w = '{32'h0BADF00D, 32'h12345678, 32'hCAFEBABE};
    bq_t img = make_image(3, w);
    bq_t part;
    for (int i = 0; i < 8; i++) part.push_back(img[i]);
    start_test();
    send(part, 0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== 32'h0 ||
        core_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: rdy=%b we=%b addr=%h wdata=%h crst=%b done=%b err=%b",
               in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    obs.delete();
    repeat (4) @(negedge clk);
    total++;
    if (obs.size() != 0) begin
      bad++;
      $display("FAIL async_reset_nowrite: writes=%0d want 0", obs.size());
    end
    acc_cyc.delete();
    send(make_image(1, '{32'h00000073}), 0);
    check_load("after_reset", '{32'h00000073});
  endtask

  task automatic test_random();
    int ns[5] = '{1, DEPTH, 0, 0, 0};
    for (int t = 0; t < 5; t++) begin
      wq_t w;
      int n = (ns[t] != 0) ? ns[t] : int'($urandom_range(2, 20));
      for (int i = 0; i < n; i++) w.push_back($urandom);
      start_test();
      send(make_image(n, w), 2);
      check_load($sformatf("random_n%0d", n), w);
    end
  endtask

  initial begin
    test_reset();
    test_nominal(0, "nominal");
    test_nominal(1, "gapped");
    test_zero();
    test_oversize();
    test_abort();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end
endmodule
